// File: rtl/db_arbiter.sv
// Round-robin arbiter sharing one data bus between two masters,
// with a per-transaction watchdog that forces completion on a hung bus.
package db_pkg;
  typedef enum logic [1:0] {
    MEM_ACCESS_NONE,
    MEM_ACCESS_READ,
    MEM_ACCESS_WRITE,
    MEM_ACCESS_FETCH
  } MEM_ACCESS_T;

  typedef enum logic [1:0] {
    MEM_LEN_BYTE,
    MEM_LEN_HALF,
    MEM_LEN_WORD,
    MEM_LEN_DWORD
  } MEM_LEN;
endpackage

module db_arbiter
  import db_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  MEM_ACCESS_T m0_accessType,
  input  MEM_LEN      m0_memLen,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  MEM_ACCESS_T m1_accessType,
  input  MEM_LEN      m1_memLen,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] db_addr,
  output logic [31:0] db_dataOut,
  output MEM_ACCESS_T db_accessType,
  output MEM_LEN      db_memLen,
  input  logic [31:0] db_dataIn,
  input  logic        db_ready,
  output logic [1:0]  grant
);

  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY0,
    S_BUSY1
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [15:0] cnt;

  logic req0, req1;
  logic own0, own1;
  logic own_req;
  logic tmo;

  always_comb begin
    req0    = (m0_accessType != MEM_ACCESS_NONE);
    req1    = (m1_accessType != MEM_ACCESS_NONE);
    own0    = (state == S_BUSY0);
    own1    = (state == S_BUSY1);
    own_req = (own0 && req0) || (own1 && req1);
    // db_ready wins over a coincident watchdog expiry
    tmo     = (own0 || own1) && (cnt == TMO_M1)
              && !db_ready;
  end

  always_comb begin
    db_addr       = '0;
    db_dataOut    = '0;
    db_accessType = MEM_ACCESS_NONE;
    db_memLen     = MEM_LEN_BYTE;
    unique case (1'b1)
      own0: begin
        db_addr       = m0_addr;
        db_dataOut    = m0_wdata;
        db_accessType = m0_accessType;
        db_memLen     = m0_memLen;
      end
      own1: begin
        db_addr       = m1_addr;
        db_dataOut    = m1_wdata;
        db_accessType = m1_accessType;
        db_memLen     = m1_memLen;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0_ready = !req0 || (own0 && (db_ready || tmo));
    m1_ready = !req1 || (own1 && (db_ready || tmo));
    m0_err   = own0 && req0 && tmo;
    m1_err   = own1 && req1 && tmo;
    m0_rdata = (own0 && db_ready) ? db_dataIn : '0;
    m1_rdata = (own1 && db_ready) ? db_dataIn : '0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || last_grant)) begin
            state      <= S_BUSY0;
            grant      <= 2'b01;
            last_grant <= 1'b0;
          end else if (req1) begin
            state      <= S_BUSY1;
            grant      <= 2'b10;
            last_grant <= 1'b1;
          end
        end
        S_BUSY0, S_BUSY1: begin
          // covers completion, watchdog expiry and abort
          if (!own_req || db_ready || tmo) begin
            state <= S_IDLE;
            grant <= 2'b00;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Vector-table bench for db_arbiter: per-cycle stimulus with
// hand-computed expectations, plus an alternation sequence.
module tb_db_arbiter;
  import db_pkg::*;

  localparam MEM_ACCESS_T N = MEM_ACCESS_NONE;
  localparam MEM_ACCESS_T R = MEM_ACCESS_READ;
  localparam MEM_ACCESS_T W = MEM_ACCESS_WRITE;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] WD0 = 32'hA0A0_A0A0;
  localparam logic [31:0] WD1 = 32'hB1B1_B1B1;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  MEM_ACCESS_T m0_accessType, m1_accessType;
  MEM_LEN      m0_memLen, m1_memLen;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] db_addr, db_dataOut, db_dataIn;
  MEM_ACCESS_T db_accessType;
  MEM_LEN      db_memLen;
  logic        db_ready;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  db_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_accessType(m0_accessType),
    .m0_memLen(m0_memLen), .m0_rdata(m0_rdata),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_accessType(m1_accessType),
    .m1_memLen(m1_memLen), .m1_rdata(m1_rdata),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .db_addr(db_addr), .db_dataOut(db_dataOut),
    .db_accessType(db_accessType),
    .db_memLen(db_memLen), .db_dataIn(db_dataIn),
    .db_ready(db_ready), .grant(grant)
  );

  typedef struct {
    logic        res;
    MEM_ACCESS_T a0, a1;
    logic        rdy;
    logic [31:0] din;
    logic [1:0]  g;
    MEM_ACCESS_T t;
    logic [31:0] da;
    logic        r0, r1, e0, e1;
    logic [31:0] d0, d1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rs, input MEM_ACCESS_T a0,
    input MEM_ACCESS_T a1, input logic rdy,
    input logic [31:0] din, input logic [1:0] g,
    input MEM_ACCESS_T t, input logic [31:0] da,
    input logic r0, input logic r1,
    input logic e0, input logic e1,
    input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.res = rs; v.a0 = a0; v.a1 = a1;
    v.rdy = rdy; v.din = din; v.g = g;
    v.t = t; v.da = da; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  initial begin
    // idle / reset state
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // both write, zero-wait: alternation starts at m0
    vq.push_back(mk(0,W,W,1,32'h11,2'b00,N,0,0,0,0,0,0,0));
    vq.push_back(mk(0,W,W,1,32'h11,2'b01,W,A0,1,0,0,0,32'h11,0));
    vq.push_back(mk(0,W,W,1,32'h11,2'b00,N,0,0,0,0,0,0,0));
    vq.push_back(mk(0,W,W,1,32'h11,2'b10,W,A1,0,1,0,0,0,32'h11));
    vq.push_back(mk(0,W,W,1,32'h11,2'b00,N,0,0,0,0,0,0,0));
    vq.push_back(mk(0,W,W,1,32'h11,2'b01,W,A0,1,0,0,0,32'h11,0));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // m0 read, ready on 3rd busy cycle
    vq.push_back(mk(0,R,N,0,0,2'b00,N,0,0,1,0,0,0,0));
    vq.push_back(mk(0,R,N,0,0,2'b01,R,A0,0,1,0,0,0,0));
    vq.push_back(mk(0,R,N,0,0,2'b01,R,A0,0,1,0,0,0,0));
    vq.push_back(mk(0,R,N,1,32'hDEADBEEF,2'b01,R,A0,
                    1,1,0,0,32'hDEADBEEF,0));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // m1 read, m0 arrives mid-transaction
    vq.push_back(mk(0,N,R,0,0,2'b00,N,0,1,0,0,0,0,0));
    vq.push_back(mk(0,W,R,0,0,2'b10,R,A1,0,0,0,0,0,0));
    vq.push_back(mk(0,W,R,0,0,2'b10,R,A1,0,0,0,0,0,0));
    vq.push_back(mk(0,W,R,1,32'hCAFEF00D,2'b10,R,A1,
                    0,1,0,0,0,32'hCAFEF00D));
    vq.push_back(mk(0,W,N,0,0,2'b00,N,0,0,1,0,0,0,0));
    vq.push_back(mk(0,W,N,1,0,2'b01,W,A0,1,1,0,0,0,0));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // m1 timeout on 4th busy cycle, rdata forced 0
    vq.push_back(mk(0,N,R,0,0,2'b00,N,0,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,32'hFFFFFFFF,2'b10,R,A1,
                    1,1,0,1,0,0));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // db_ready exactly at 4th busy cycle: no err
    vq.push_back(mk(0,N,R,0,0,2'b00,N,0,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,0,0,2'b10,R,A1,1,0,0,0,0,0));
    vq.push_back(mk(0,N,R,1,32'h12345678,2'b10,R,A1,
                    1,1,0,0,0,32'h12345678));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));
    // reset in BUSY0, then tie goes to m0
    vq.push_back(mk(0,R,N,0,0,2'b00,N,0,0,1,0,0,0,0));
    vq.push_back(mk(1,R,N,0,0,2'b01,R,A0,0,1,0,0,0,0));
    vq.push_back(mk(0,R,R,0,0,2'b00,N,0,0,0,0,0,0,0));
    vq.push_back(mk(0,R,R,1,32'h55,2'b01,R,A0,
                    1,0,0,0,32'h55,0));
    vq.push_back(mk(0,N,N,0,0,2'b00,N,0,1,1,0,0,0,0));

    m0_addr = A0; m1_addr = A1;
    m0_wdata = WD0; m1_wdata = WD1;
    m0_memLen = MEM_LEN_WORD;
    m1_memLen = MEM_LEN_BYTE;
    m0_accessType = N; m1_accessType = N;
    db_ready = 1'b0; db_dataIn = '0;
    res = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      res           = vq[i].res;
      m0_accessType = vq[i].a0;
      m1_accessType = vq[i].a1;
      db_ready      = vq[i].rdy;
      db_dataIn     = vq[i].din;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vq[i].g));
      chk($sformatf("v%0d db_type", i),
          32'(db_accessType), 32'(vq[i].t));
      chk($sformatf("v%0d db_addr", i), db_addr, vq[i].da);
      chk($sformatf("v%0d m0_ready", i),
          32'(m0_ready), 32'(vq[i].r0));
      chk($sformatf("v%0d m1_ready", i),
          32'(m1_ready), 32'(vq[i].r1));
      chk($sformatf("v%0d m0_err", i),
          32'(m0_err), 32'(vq[i].e0));
      chk($sformatf("v%0d m1_err", i),
          32'(m1_err), 32'(vq[i].e1));
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vq[i].d0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vq[i].d1);
    end

    // last grant went to m0, so this tie starts with m1
    begin
      logic nxt1;
      logic [1:0] eg;
      nxt1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        res = 1'b0;
        m0_accessType = W;
        m1_accessType = W;
        db_ready = 1'b1;
        db_dataIn = 32'h0;
        #1;
        if (i % 2 == 0) begin
          eg = 2'b00;
        end else begin
          eg = nxt1 ? 2'b10 : 2'b01;
          nxt1 = !nxt1;
        end
        chk($sformatf("alt%0d grant", i), 32'(grant), 32'(eg));
        if (eg == 2'b01) begin
          chk($sformatf("alt%0d addr", i), db_addr, A0);
          chk($sformatf("alt%0d wdata", i), db_dataOut, WD0);
          chk($sformatf("alt%0d len", i),
              32'(db_memLen), 32'(MEM_LEN_WORD));
        end else if (eg == 2'b10) begin
          chk($sformatf("alt%0d addr", i), db_addr, A1);
          chk($sformatf("alt%0d wdata", i), db_dataOut, WD1);
          chk($sformatf("alt%0d len", i),
              32'(db_memLen), 32'(MEM_LEN_BYTE));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/db_arbiter.md
# db_arbiter

Two-master arbiter that shares the single physical data bus between the CPU/MMU side (master 0) and a secondary bus master such as a DMA or debug port (master 1). The arbiter sits between both masters and the memory/IO bus. It grants one transaction at a time with round-robin fairness and holds the grant until the bus signals completion. A watchdog counter terminates transactions the bus never completes and reports an error to the owning master.

## Interface
- `TIMEOUT`, default 255: number of BUSY cycles without `db_ready` before forced termination. Legal range 2..65535.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `res`  in  1  synchronous, active-high reset.
- `mN_addr`  in  32  byte address from master N (N = 0, 1).
- `mN_wdata`  in  32  write data from master N.
- `mN_accessType`  in  `MEM_ACCESS_T`  request type; any value other than `MEM_ACCESS_NONE` is a request.
- `mN_memLen`  in  `MEM_LEN`  access length.
- `mN_rdata`  out  32  read data returned to master N.
- `mN_ready`  out  1  transaction done, or master N idle.
- `mN_err`  out  1  one-cycle pulse, coincident with `mN_ready`, when master N's transaction timed out.
- `db_addr`, `db_dataOut`  out  32  address and write data to the bus.
- `db_accessType`  out  `MEM_ACCESS_T`  bus access type.
- `db_memLen`  out  `MEM_LEN`  bus access length.
- `db_dataIn`  in  32  read data from the bus.
- `db_ready`  in  1  bus completion.
- `grant`  out  2  one-hot owner; bit N set means master N owns the bus; 2'b00 in IDLE.

## Operation
- States:
  - S_IDLE: no owner; `db_accessType` = `MEM_ACCESS_NONE`.
  - S_BUSY0: master 0 owns the bus.
  - S_BUSY1: master 1 owns the bus.
- Arbitration in S_IDLE:
  - Only master N requests: next state is S_BUSYN.
  - Both masters request: the master not served last wins.
  - `lastGrant` register updates on every S_IDLE→S_BUSYN transition.
- In S_BUSYN, `db_addr`, `db_dataOut`, `db_accessType` and `db_memLen` are driven combinationally from master N. Other masters' signals are ignored.
- Outputs to master N:
  - `mN_rdata` = `db_dataIn` when N owns the bus and `db_ready`=1; 0 on timeout; otherwise don't-care (drive 0).
  - `mN_ready` = 1 when master N is not requesting, OR when it owns the bus and (`db_ready` OR timeout).
  - A requesting master that does not own the bus sees `mN_ready`=0.
- S_BUSYN transitions:
  - `db_ready`=1 → S_IDLE.
  - Timeout → S_IDLE, with `mN_err`=1 for that cycle.
  - Master N drops its request (`MEM_ACCESS_NONE`) before completion → abort to S_IDLE, no `mN_ready` completion pulse.
  - Otherwise stay in S_BUSYN.
- Watchdog counter:
  - 16 bits, cleared in S_IDLE.
  - Increments each S_BUSYN cycle without `db_ready`.
  - Timeout condition is `count == TIMEOUT-1` with `db_ready`=0.
  - If `db_ready` and the timeout condition occur in the same cycle, `db_ready` wins: normal completion, `err`=0.
- Masters hold all request signals stable from request until `mN_ready`. The arbiter does not latch them.

## Timing
- Reset values (after a clock edge with `res`=1, regardless of current state):
  - state S_IDLE, `grant`=2'b00, `lastGrant`=1 (master 0 wins the first tie), counter 0, `mN_err`=0.
  - `db_accessType` = `MEM_ACCESS_NONE`.
  - `mN_ready` = 1 for non-requesting masters.
- Reset during S_BUSYN abandons the transaction. No ready or err pulse is issued.
- Latency:
  - Request seen in S_IDLE at cycle 0; bus access presented at cycle 1.
  - `mN_ready` is asserted in the same cycle as `db_ready`.
  - The state returns to S_IDLE on the following edge.
  - Minimum 2 cycles per transaction; a back-to-back request by the other master is granted in that S_IDLE cycle.
- A zero-wait bus (`db_ready` always 1) with both masters requesting continuously gives the pattern BUSY0, IDLE, BUSY1, IDLE, …, i.e. strict alternation.
- Timeout: `mN_ready`/`mN_err` are asserted in the `TIMEOUT`-th BUSY cycle (cycle `TIMEOUT` after grant).

## Test plan
- Reset, then idle:
  - `grant`=00, `db_accessType`=NONE, `m0_ready`=`m1_ready`=1, `mN_err`=0.
- Master 0 reads 0x0000_1000; bus gives `db_ready` on the 3rd BUSY cycle with `db_dataIn`=0xDEADBEEF:
  - `m0_rdata`=0xDEADBEEF with `m0_ready`=1 in that cycle.
  - `m1_ready` stays 1 throughout.
- Both masters request writes continuously; zero-wait bus:
  - Grants alternate 01, 00, 10, 00, …, starting with master 0.
  - `db_addr` matches the owner's address in every BUSY cycle.
- Master 1 reads while master 0 requests mid-transaction:
  - `m0_ready`=0 until master 1 completes.
  - Master 0 is granted at the next S_IDLE.
- `TIMEOUT`=4; bus never ready:
  - `m1_ready`=`m1_err`=1 in the 4th BUSY cycle, with `m1_rdata`=0.
  - State is S_IDLE next cycle.
  - `db_ready` arriving exactly at the 4th cycle → `err`=0.
- `res` pulsed during S_BUSY0:
  - Next cycle `grant`=00, `db_accessType`=NONE, no `m0_ready`/`m0_err` pulse.
  - The next tie is won by master 0.
